// File: rtl/vend_pkg.sv
// Shared types and helpers for the multi-product vending controller.
// Price lists are carried as a fixed-width vector so one helper serves every parameterisation.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT   = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } vend_state_t;

  localparam int MAX_ITEMS   = 16;
  localparam int MAX_BAL_W   = 16;
  localparam int PRICE_VEC_W = MAX_ITEMS * MAX_BAL_W;

  function automatic int unsigned max_balance(input int unsigned bal_w);
    return (32'd1 << bal_w) - 32'd1;
  endfunction

  function automatic logic [MAX_BAL_W-1:0] price_of(input logic [PRICE_VEC_W-1:0] prices,
                                                    input int unsigned idx,
                                                    input int unsigned bal_w);
    logic [MAX_BAL_W-1:0] mask;
    mask = MAX_BAL_W'(max_balance(bal_w));
    return MAX_BAL_W'(prices >> (idx * bal_w)) & mask;
  endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-item stock counters with saturating restock and dispense decrement.
// Only instantiated when VEND_STOCK_EN is defined.
module vend_stock_bank
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS  = 4,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dec,
  input  logic [$clog2(NUM_ITEMS)-1:0] dec_item,
  input  logic                         restock,
  input  logic [$clog2(NUM_ITEMS)-1:0] restock_item,
  input  logic [STOCK_W-1:0]           restock_qty,
  output logic [NUM_ITEMS-1:0]         sold_out
);

  localparam logic [STOCK_W+1:0] STOCK_MAX = (STOCK_W+2)'((1 << STOCK_W) - 1);

  for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_item
    logic [STOCK_W-1:0] cnt;
    logic [STOCK_W-1:0] cnt_nxt;
    logic [STOCK_W+1:0] sum;
    logic               add_hit;
    logic               dec_hit;
    logic               empty_r;

    assign add_hit = restock && (32'(restock_item) == i);
    assign dec_hit = dec && (32'(dec_item) == i);
    // dec only fires on a non-empty item, so the subtraction cannot go below zero
    assign sum     = (STOCK_W+2)'(cnt)
                   + (add_hit ? (STOCK_W+2)'(restock_qty) : '0)
                   - (STOCK_W+2)'(dec_hit);
    assign cnt_nxt = (sum > STOCK_MAX) ? STOCK_MAX[STOCK_W-1:0] : sum[STOCK_W-1:0];

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt     <= STOCK_W'(STOCK_INIT);
        empty_r <= 1'b0;
      end else begin
        cnt     <= cnt_nxt;
        empty_r <= (cnt_nxt == '0);
      end
    end

    assign sold_out[i] = empty_r;
  end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: coin credit, selection, dispense and change return.
// Optional per-item stock tracking is enabled by defining VEND_STOCK_EN.
//
// state    | meaning
// IDLE     | no credit, waiting for first coin
// CREDIT   | credit held, accepting coins / selection / cancel
// DISPENSE | dispense pulse active, change decision next
// CHANGE   | change pulse active, returning to IDLE
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int                         NUM_ITEMS  = 4,
  parameter int                         COIN_W     = 3,
  parameter int                         BAL_W      = 6,
  parameter logic [NUM_ITEMS*BAL_W-1:0] PRICES     = {6'd5, 6'd4, 6'd3, 6'd2},
  parameter int                         STOCK_W    = 4,
  parameter int                         STOCK_INIT = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [COIN_W-1:0]            coin,
  input  logic                         coin_valid,
  input  logic [$clog2(NUM_ITEMS)-1:0] sel,
  input  logic                         sel_valid,
  input  logic                         cancel,
  input  logic                         restock,
  input  logic [$clog2(NUM_ITEMS)-1:0] restock_item,
  input  logic [STOCK_W-1:0]           restock_qty,
  output logic [NUM_ITEMS-1:0]         dispense,
  output logic [BAL_W-1:0]             change,
  output logic                         change_valid,
  output logic                         coin_reject,
  output logic                         sel_err,
  output logic [BAL_W-1:0]             balance,
  output logic [NUM_ITEMS-1:0]         sold_out
);

  localparam logic [PRICE_VEC_W-1:0] PRICE_VEC = PRICE_VEC_W'(PRICES);
  localparam logic [BAL_W:0]         BAL_MAX   = (BAL_W+1)'(max_balance(BAL_W));

  vend_state_t          state, state_nxt;
  logic [BAL_W-1:0]     bal_nxt, chg_nxt, sel_price;
  logic [NUM_ITEMS-1:0] disp_nxt;
  logic                 cv_nxt, rej_nxt, serr_nxt;
  logic [BAL_W:0]       coin_sum;
  logic                 coin_fits, sel_in_range, accept, accept_fire;
  logic [BAL_W-1:0]     price_tbl [NUM_ITEMS];

  for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_price
    assign price_tbl[i] = BAL_W'(price_of(PRICE_VEC, i, BAL_W));
  end

  assign sel_price    = price_tbl[sel];
  assign sel_in_range = (32'(sel) < NUM_ITEMS);
  assign accept       = sel_valid && sel_in_range && !sold_out[sel] && (balance >= sel_price);
  assign accept_fire  = (state == CREDIT) && !cancel && accept;
  // widened sum so an overflowing coin is refused instead of wrapping
  assign coin_sum     = {1'b0, balance} + (BAL_W+1)'(coin);
  assign coin_fits    = (coin_sum <= BAL_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      balance      <= '0;
      dispense     <= '0;
      change       <= '0;
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      sel_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      balance      <= bal_nxt;
      dispense     <= disp_nxt;
      change       <= chg_nxt;
      change_valid <= cv_nxt;
      coin_reject  <= rej_nxt;
      sel_err      <= serr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (coin_valid && coin != '0) state_nxt = CREDIT;
      CREDIT:   if (cancel) state_nxt = CHANGE;
                else if (accept) state_nxt = DISPENSE;
      DISPENSE: state_nxt = (balance != '0) ? CHANGE : IDLE;
      CHANGE:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // change is issued on entry to CHANGE so it lands one cycle after dispense
  always_comb begin
    bal_nxt  = balance;
    disp_nxt = '0;
    chg_nxt  = change;
    cv_nxt   = 1'b0;
    rej_nxt  = 1'b0;
    serr_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (coin_valid && coin != '0) bal_nxt = BAL_W'(coin);
        serr_nxt = sel_valid;
      end
      CREDIT: begin
        if (cancel) begin
          rej_nxt = coin_valid;
          cv_nxt  = 1'b1;
          chg_nxt = balance;
          bal_nxt = '0;
        end else if (sel_valid) begin
          rej_nxt = coin_valid;
          if (accept) begin
            disp_nxt = {{(NUM_ITEMS-1){1'b0}}, 1'b1} << sel;
            bal_nxt  = balance - sel_price;
          end else begin
            serr_nxt = 1'b1;
          end
        end else if (coin_valid) begin
          if (coin_fits) bal_nxt = coin_sum[BAL_W-1:0];
          else           rej_nxt = 1'b1;
        end
      end
      DISPENSE: begin
        rej_nxt = coin_valid;
        if (balance != '0) begin
          cv_nxt  = 1'b1;
          chg_nxt = balance;
          bal_nxt = '0;
        end
      end
      CHANGE:  rej_nxt = coin_valid;
      default: ;
    endcase
  end

`ifdef VEND_STOCK_EN
  vend_stock_bank #(
    .NUM_ITEMS  (NUM_ITEMS),
    .STOCK_W    (STOCK_W),
    .STOCK_INIT (STOCK_INIT)
  ) u_stock (
    .clk          (clk),
    .reset        (reset),
    .dec          (accept_fire),
    .dec_item     (sel),
    .restock      (restock),
    .restock_item (restock_item),
    .restock_qty  (restock_qty),
    .sold_out     (sold_out)
  );
`else
  localparam int UNUSED_STOCK_INIT = STOCK_INIT;
  logic unused_stock;
  assign unused_stock = ^{restock, restock_item, restock_qty, accept_fire};
  assign sold_out     = '0;
`endif

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Scoreboard bench for vend_ctrl_multi: a transaction-level model predicts every cycle's outputs,
// a monitor compares them against the DUT. Stock checks are active when VEND_STOCK_EN is defined.
module tb_vend_ctrl_multi;

  localparam int MAX_BAL   = 63;
  localparam int MAX_STOCK = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] coin = '0;
  logic       coin_valid = 1'b0;
  logic [1:0] sel = '0;
  logic       sel_valid = 1'b0;
  logic       cancel = 1'b0;
  logic       restock = 1'b0;
  logic [1:0] restock_item = '0;
  logic [3:0] restock_qty = '0;
  logic [3:0] dispense;
  logic [5:0] change;
  logic       change_valid;
  logic       coin_reject;
  logic       sel_err;
  logic [5:0] balance;
  logic [3:0] sold_out;

  vend_ctrl_multi dut (
    .clk          (clk),
    .reset        (reset),
    .coin         (coin),
    .coin_valid   (coin_valid),
    .sel          (sel),
    .sel_valid    (sel_valid),
    .cancel       (cancel),
    .restock      (restock),
    .restock_item (restock_item),
    .restock_qty  (restock_qty),
    .dispense     (dispense),
    .change       (change),
    .change_valid (change_valid),
    .coin_reject  (coin_reject),
    .sel_err      (sel_err),
    .balance      (balance),
    .sold_out     (sold_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       bal;
    logic [3:0] disp;
    int       chg;
    bit       cv;
    bit       rej;
    bit       serr;
    logic [3:0] sold;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // model of the customer-visible machine: where the transaction is, not how it is encoded
  localparam int M_IDLE = 0, M_CREDIT = 1, M_VEND = 2, M_RET = 3;
  int         m_mode = M_IDLE;
  int         m_bal = 0;
  int         m_chg = 0;
  logic [3:0] m_disp = '0;
  bit         m_cv, m_rej, m_serr;
  int         m_stock[4] = '{3, 3, 3, 3};
  logic [3:0] m_sold = '0;
  int         price_tbl[4] = '{2, 3, 4, 5};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refund();
    m_cv   = 1'b1;
    m_chg  = m_bal;
    m_bal  = 0;
    m_mode = M_RET;
  endtask

  task automatic model_step();
    int   dec_item;
    int   s;
    exp_t e;
    dec_item = -1;
    if (reset) begin
      m_mode = M_IDLE; m_bal = 0; m_chg = 0; m_disp = '0;
      m_cv = 0; m_rej = 0; m_serr = 0; m_sold = '0;
      for (int i = 0; i < 4; i++) m_stock[i] = 3;
    end else begin
      m_disp = '0; m_cv = 0; m_rej = 0; m_serr = 0;
      case (m_mode)
        M_IDLE: begin
          if (coin_valid && coin != 0) begin
            m_bal  = int'(coin);
            m_mode = M_CREDIT;
          end
          if (sel_valid) m_serr = 1;
        end
        M_CREDIT: begin
          if (cancel) begin
            m_rej = coin_valid;
            refund();
          end else if (sel_valid) begin
            m_rej = coin_valid;
            if (!m_sold[sel] && m_bal >= price_tbl[sel]) begin
              m_disp[sel] = 1'b1;
              m_bal      -= price_tbl[sel];
              dec_item    = int'(sel);
              m_mode      = M_VEND;
            end else begin
              m_serr = 1;
            end
          end else if (coin_valid) begin
            if (m_bal + int'(coin) <= MAX_BAL) m_bal += int'(coin);
            else m_rej = 1;
          end
        end
        M_VEND: begin
          m_rej = coin_valid;
          if (m_bal > 0) refund();
          else m_mode = M_IDLE;
        end
        default: begin
          m_rej  = coin_valid;
          m_mode = M_IDLE;
        end
      endcase
`ifdef VEND_STOCK_EN
      for (int i = 0; i < 4; i++) begin
        s = m_stock[i];
        if (restock && int'(restock_item) == i) s += int'(restock_qty);
        if (dec_item == i) s -= 1;
        if (s > MAX_STOCK) s = MAX_STOCK;
        m_stock[i] = s;
        m_sold[i]  = (s == 0);
      end
`endif
    end
    e.bal = m_bal; e.disp = m_disp; e.chg = m_chg; e.cv = m_cv;
    e.rej = m_rej; e.serr = m_serr; e.sold = m_sold;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit r = 0, input bit cv = 0, input logic [2:0] c = 0,
                       input bit sv = 0, input logic [1:0] s = 0, input bit can = 0,
                       input bit rs = 0, input logic [1:0] ri = 0, input logic [3:0] rq = 0);
    @(negedge clk);
    reset = r; coin_valid = cv; coin = c; sel_valid = sv; sel = s; cancel = can;
    restock = rs; restock_item = ri; restock_qty = rq;
    model_step();
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("balance",      32'(balance),      32'(e.bal));
        chk("dispense",     32'(dispense),     32'(e.disp));
        chk("change_valid", 32'(change_valid), 32'(e.cv));
        chk("change",       32'(change),       32'(e.chg));
        chk("coin_reject",  32'(coin_reject),  32'(e.rej));
        chk("sel_err",      32'(sel_err),      32'(e.serr));
        chk("sold_out",     32'(sold_out),     32'(e.sold));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    drive(.r(1));
    drive(.r(1));
    settle();
    chk("reset_balance", 32'(balance), 32'd0);
    chk("reset_outputs", 32'({dispense, change_valid, coin_reject, sel_err}), 32'd0);

    // two coins then a price-3 item, one unit of change
    drive(.cv(1), .c(2));
    drive(.cv(1), .c(2));
    drive(.sv(1), .s(1));
    settle();
    chk("t1_dispense", 32'(dispense), 32'b0010);
    drive();
    settle();
    chk("t1_change", 32'({change_valid, change}), 32'({1'b1, 6'd1}));
    drive();

    // unaffordable selection, then cancel refunds
    drive(.cv(1), .c(2));
    drive(.sv(1), .s(3));
    settle();
    chk("t2_sel_err", 32'({sel_err, balance}), 32'({1'b1, 6'd2}));
    drive(.can(1));
    settle();
    chk("t2_refund", 32'({change_valid, change}), 32'({1'b1, 6'd2}));
    drive();

    // credit overflow guard at the top of the balance range
    for (int i = 0; i < 8; i++) drive(.cv(1), .c(7));
    drive(.cv(1), .c(4));
    drive(.cv(1), .c(7));
    settle();
    chk("t3_reject", 32'({coin_reject, balance}), 32'({1'b1, 6'd60}));
    drive(.cv(1), .c(3));
    settle();
    chk("t3_full", 32'(balance), 32'd63);
    drive(.can(1));
    drive();

    // selection wins over a simultaneous coin
    drive(.cv(1), .c(5));
    drive(.sv(1), .s(0), .cv(1), .c(3));
    settle();
    chk("t4_both", 32'({dispense, coin_reject, balance}), 32'({4'b0001, 1'b1, 6'd3}));
    drive();
    drive();

`ifdef VEND_STOCK_EN
    for (int k = 0; k < 3; k++) begin
      drive(.cv(1), .c(4));
      drive(.sv(1), .s(2));
      drive();
    end
    settle();
    chk("t5_sold_out", 32'(sold_out[2]), 32'd1);
    drive(.cv(1), .c(4));
    drive(.sv(1), .s(2));
    settle();
    chk("t5_refused", 32'(sel_err), 32'd1);
    drive(.rs(1), .ri(2), .rq(1));
    settle();
    chk("t5_restock", 32'(sold_out[2]), 32'd0);
    drive(.can(1));
    drive();
`endif

    // reset in the middle of a credit discards it silently
    drive(.cv(1), .c(4));
    drive(.r(1));
    settle();
    chk("t6_reset", 32'({change_valid, balance}), 32'd0);
    drive();

    for (int n = 0; n < 3000; n++) begin
      drive(.r($urandom_range(0, 199) == 0),
            .cv($urandom_range(0, 9) < 4),
            .c(3'($urandom_range(0, 7))),
            .sv($urandom_range(0, 9) < 2),
            .s(2'($urandom_range(0, 3))),
            .can($urandom_range(0, 24) < 2),
            .rs($urandom_range(0, 9) == 0),
            .ri(2'($urandom_range(0, 3))),
            .rq(4'($urandom_range(0, 15))));
    end
    drive();
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vend_ctrl_multi.md
Name: vend_ctrl_multi

Overview:
Parametrised successor to the single-product-set vending FSM. Supports NUM_ITEMS products with per-item prices, coin-by-coin credit accumulation with an overflow guard, cancel/refund and explicit change return. Optional per-item stock tracking. Sits between the coin acceptor front end and the dispenser actuator/change hopper drivers.

Parameters:
NUM_ITEMS, 4, number of selectable products (2..16)
COIN_W, 3, width of coin value input
BAL_W, 6, balance/price/change width; max balance is 2^BAL_W-1
PRICES, {6'd5,6'd4,6'd3,6'd2}, packed NUM_ITEMS x BAL_W price list; item i at bits [i*BAL_W +: BAL_W]
STOCK_W, 4, per-item stock counter width (VEND_STOCK_EN only)
STOCK_INIT, 3, stock value per item after reset (VEND_STOCK_EN only)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
coin  in  COIN_W  coin value; valid when coin_valid=1
coin_valid  in  1  one-cycle strobe per inserted coin
sel  in  $clog2(NUM_ITEMS)  product index
sel_valid  in  1  one-cycle selection strobe
cancel  in  1  one-cycle refund request
restock  in  1  add restock_qty to item restock_item (VEND_STOCK_EN)
restock_item  in  $clog2(NUM_ITEMS)  restock target
restock_qty  in  STOCK_W  restock amount
dispense  out  NUM_ITEMS  one-hot, one-cycle pulse
change  out  BAL_W  change amount; valid with change_valid
change_valid  out  1  one-cycle pulse
coin_reject  out  1  one-cycle pulse: coin not credited, hopper returns it
sel_err  out  1  one-cycle pulse: selection refused
balance  out  BAL_W  current credit
sold_out  out  NUM_ITEMS  level; bit i = stock of item i is 0

Behaviour:
- All outputs registered. On reset: state IDLE, balance=0, dispense=0, change=0, change_valid=0, coin_reject=0, sel_err=0, sold_out=0, stocks=STOCK_INIT. Reset mid-transaction discards credit; no change is issued.
- States: IDLE, CREDIT, DISPENSE, CHANGE.
- IDLE: coin_valid with coin!=0 -> balance=coin, go CREDIT. coin_valid with coin=0 is ignored. sel_valid or cancel -> sel_err pulse if sel_valid, otherwise ignored.
- CREDIT, priority cancel > sel_valid > coin_valid:
  - cancel: go CHANGE.
  - sel_valid: accepted iff sel<NUM_ITEMS, !sold_out[sel] and balance>=PRICES[sel]. Accepted -> next cycle dispense[sel]=1, balance-=price, stock[sel]-=1, state DISPENSE. Refused -> sel_err pulse next cycle, stay CREDIT, balance unchanged.
  - coin_valid alone: if balance+coin (BAL_W+1-bit sum) <= 2^BAL_W-1, credit it; otherwise coin_reject pulse and balance unchanged. No wrap-around.
  - A coin_valid in the same cycle as a winning cancel or sel_valid -> coin_reject.
- DISPENSE (1 cycle): dispense returns to 0. balance>0 -> CHANGE; balance=0 -> IDLE. coin_valid -> coin_reject.
- CHANGE (1 cycle): change=balance, change_valid=1, balance=0, go IDLE. If balance is 0 on a cancel, change_valid still pulses with change=0. coin_valid -> coin_reject.
- Latency: coin at cycle N -> balance updated N+1. Accepted sel at N -> dispense N+1, change_valid N+2.
- Only one dispense bit is ever high. The change output holds its last value when change_valid=0.

Optional Feature:
VEND_STOCK_EN
- Defined: per-item STOCK_W counters. Stock decrements on dispense. restock saturates at 2^STOCK_W-1 and is accepted in any state. If restock and dispense hit the same item in the same cycle, the net result is stock+qty-1, saturated. sold_out reflects stock==0, registered.
- Undefined: no counters. sold_out is tied to 0. restock, restock_item and restock_qty are ignored. Stock never refuses a selection.

Decomposition:
- Package vend_pkg holds:
  - state enum vend_state_t {IDLE,CREDIT,DISPENSE,CHANGE};
  - function price_of(PRICES, idx);
  - localparam for max-balance computation.
- Sub-module vend_stock_bank, instantiated only under VEND_STOCK_EN, holds the stock counters, restock/decrement arbitration and sold_out generation.

Test Plan:
1. Default params. Coins 2,2 then sel=1 (price 3) -> dispense=4'b0010 one cycle, next cycle change_valid=1, change=1, then IDLE, balance=0.
2. Coin 2, sel=3 (price 5) -> sel_err pulse, balance stays 2. Then cancel -> change=2, change_valid=1.
3. BAL_W=6, balance 60, coin 7 -> coin_reject, balance 60. Coin 3 -> balance 63.
4. Same cycle sel_valid=0 (affordable) and coin_valid=3 -> dispense[0]=1, coin_reject=1, balance excludes the 3.
5. VEND_STOCK_EN, STOCK_INIT=3. Buy item 2 three times -> sold_out[2]=1; fourth attempt gives sel_err. restock item 2 qty 1 -> sold_out[2]=0.
6. Balance 4 in CREDIT, assert reset one cycle -> balance=0, no change_valid, state IDLE, outputs at reset values.
